// File: rtl/median_pkg.sv
// median_pkg: shared constants, window-size encodings and controller states
package median_pkg;
  localparam int HALF = 5;
  localparam int WIN_MAX = 11;
  localparam logic [1:0] WS_11 = 2'b00;
  localparam logic [1:0] WS_9 = 2'b01;
  localparam logic [1:0] WS_7 = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH_ROW, DONE} state_t;
  function automatic logic [1:0] coerce_ws(input logic [1:0] ws);
    return ws == 2'b10 ? WS_7 : ws;
  endfunction
endpackage

// File: rtl/raster_counter.sv
// raster_counter: column/row shift-slot counter with programmable bounds
// Ports: clr restarts at (0,0); en advances one slot; col_last/row_last are
// inclusive bounds; col/row current position; last_wrap marks the slot that
// wraps col_last on row row_last.
module raster_counter #(
  parameter int CW = 12,
  parameter int RW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] col_last,
  input  logic [RW-1:0] row_last,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last_wrap
);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic wrap;
  assign wrap = en & (col_q == col_last);
  assign last_wrap = wrap & (row_q == row_last);
  assign col = col_q;
  assign row = row_q;
  always_comb begin
    col_d = clr ? '0 : wrap ? '0 : en ? col_q + 1'b1 : col_q;
    row_d = clr ? '0 : wrap ? row_q + 1'b1 : row_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
endmodule

// File: rtl/median_window_ctrl.sv
// median_window_ctrl: shift sequencer for the 11x11 median window array
// Ports: start/cfg_* load a frame; in_valid/in_ready accept raster pixels;
// stall freezes shifting; clken shifts line buffers and window; pad_row/pad_col
// select border padding; win_valid/win_row/win_col flag a completed centred
// window; busy/done/cfg_err report frame status; window_size is the latched size.
module median_window_ctrl
  import median_pkg::*;
#(
  parameter int W_BITS = 11,
  parameter int H_BITS = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W_BITS-1:0] cfg_width,
  input  logic [H_BITS-1:0] cfg_height,
  input  logic [1:0]        cfg_window_size,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  output logic              clken,
  output logic              pad_row,
  output logic              pad_col,
  output logic [1:0]        window_size,
  output logic              win_valid,
  output logic [H_BITS-1:0] win_row,
  output logic [W_BITS-1:0] win_col,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);
  // One extra bit so width+HALF and height+HALF never overflow
  localparam int CW = W_BITS + 1;
  localparam int RW = H_BITS + 1;
  state_t state_q, state_d;
  logic [W_BITS-1:0] width_q, width_d, wcol_q, wcol_d;
  logic [H_BITS-1:0] height_q, height_d, wrow_q, wrow_d;
  logic [1:0] ws_q, ws_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, wv_q, wv_d;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic last_wrap, accept, run, flush, in_slot, win;
  assign run = state_q == RUN;
  assign flush = state_q == FLUSH_ROW;
  assign accept = (state_q == IDLE) & start & (cfg_width >= W_BITS'(HALF + 1))
                  & (cfg_height >= H_BITS'(HALF + 1));
  assign in_slot = col < {1'b0, width_q};
  assign in_ready = run & in_slot & ~stall;
  assign clken = ~stall & (flush | (run & (~in_slot | in_valid)));
  assign pad_col = (run | flush) & ~in_slot;
  assign pad_row = flush;
  assign win = clken & (row >= RW'(HALF)) & (col >= CW'(HALF));
  raster_counter #(.CW(CW), .RW(RW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .en       (clken),
    .col_last ({1'b0, width_q} + CW'(HALF - 1)),
    .row_last (run ? {1'b0, height_q} - RW'(1) : {1'b0, height_q} + RW'(HALF - 1)),
    .col      (col),
    .row      (row),
    .last_wrap(last_wrap)
  );
  always_comb begin
    state_d = state_q;
    width_d = width_q;
    height_d = height_q;
    ws_d = ws_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = 1'b0;
    wv_d = win;
    wrow_d = win ? H_BITS'(row - RW'(HALF)) : wrow_q;
    wcol_d = win ? W_BITS'(col - CW'(HALF)) : wcol_q;
    case (state_q)
      IDLE: begin
        err_d = start & ~accept;
        if (accept) begin
          state_d = RUN;
          width_d = cfg_width;
          height_d = cfg_height;
          ws_d = coerce_ws(cfg_window_size);
          busy_d = 1'b1;
        end
      end
      RUN: state_d = last_wrap ? FLUSH_ROW : RUN;
      FLUSH_ROW: begin
        state_d = last_wrap ? DONE : FLUSH_ROW;
        done_d = last_wrap;
        busy_d = ~last_wrap;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      width_q <= '0;
      height_q <= '0;
      ws_q <= WS_11;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      wv_q <= 1'b0;
      wrow_q <= '0;
      wcol_q <= '0;
    end else begin
      state_q <= state_d;
      width_q <= width_d;
      height_q <= height_d;
      ws_q <= ws_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      wv_q <= wv_d;
      wrow_q <= wrow_d;
      wcol_q <= wcol_d;
    end
  assign window_size = ws_q;
  assign busy = busy_q;
  assign done = done_q;
  assign cfg_err = err_q;
  assign win_valid = wv_q;
  assign win_row = wrow_q;
  assign win_col = wcol_q;
endmodule

// File: doc/median_window_ctrl.md
# median_window_ctrl

Sequencing controller for the 11x11 median-filter window datapath. It accepts a raster pixel stream over a valid/ready handshake and generates the column-shift enable for the window register array. It also produces row/column border-padding selects for the line-buffer read mux, latches the per-frame window size, and flags which shifts complete a valid centred window. It sits between the input stream and the line buffers/window array, ahead of the median sorter.

## Interface
- W_BITS, 11 — width of column counter / cfg_width (max line 2047 px)
- H_BITS, 11 — width of row counter / cfg_height
- HALF, 5 — window half-size (11x11 max window, centre offset)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  frame start pulse, sampled only in IDLE
- cfg_width  in  W_BITS  pixels per line, sampled with start
- cfg_height  in  H_BITS  lines per frame, sampled with start
- cfg_window_size  in  2  00=11x11, 01=9x9, 11=7x7; 10 coerced to 11 at latch
- in_valid  in  1  input pixel valid
- in_ready  out  1  controller accepts pixel this cycle
- stall  in  1  downstream back-pressure; freezes all shifting
- clken  out  1  shift enable to line buffers and window array
- pad_row  out  1  current shift's new column lies beyond last input row (flush)
- pad_col  out  1  current shift lies beyond last input column (flush)
- window_size  out  2  latched frame window size
- win_valid  out  1  window array holds a valid centred window
- win_row  out  H_BITS  centre row of valid window
- win_col  out  W_BITS  centre column of valid window
- busy  out  1  high from accepted start until frame done
- done  out  1  one-cycle pulse after last window
- cfg_err  out  1  one-cycle pulse when start rejected

## Operation
- States: IDLE, RUN, FLUSH_ROW, DONE.
- IDLE: on start, if cfg_width < HALF+1 or cfg_height < HALF+1, pulse cfg_err and stay IDLE. Otherwise latch config, clear row_cnt/col_cnt, and go to RUN. start outside IDLE is ignored.
- Each line consumes cfg_width+HALF shift slots. col_cnt runs 0..cfg_width+HALF-1, then wraps to 0 and row_cnt increments.
- Slot with col_cnt < cfg_width in RUN: in_ready = ~stall; clken = in_valid & ~stall; pad_col = 0.
- Slot with col_cnt >= cfg_width (column flush): in_ready = 0; clken = ~stall; pad_col = 1.
- RUN covers row_cnt 0..cfg_height-1. At wrap of the last input row, go to FLUSH_ROW.
- FLUSH_ROW covers row_cnt cfg_height..cfg_height+HALF-1. in_ready = 0; clken = ~stall every slot; pad_row = 1.
- At wrap of the final flush row, go to DONE. DONE pulses done for one cycle, deasserts busy, and returns to IDLE.
- A shift completes a valid window iff row_cnt >= HALF and col_cnt >= HALF. The centre is at (row_cnt-HALF, col_cnt-HALF).
- Counter arithmetic is unsigned; the row bound cfg_height+HALF is computed in H_BITS+1 bits.

## Timing
- Reset: state IDLE, counters 0, window_size 2'b00; in_ready, clken, pad_row, pad_col, win_valid, win_row, win_col, busy, done, cfg_err all 0.
- clken, in_ready, pad_row, pad_col are combinational from state, counters and stall/in_valid. An accepted pixel shifts in the same cycle.
- win_valid/win_row/win_col are registered: asserted the cycle after the qualifying clken, aligned with the window array's updated contents. They hold for exactly one cycle per qualifying shift.
- stall = 1: no clken, counters frozen, win_valid low next cycle. A stall cycle that coincides with a counter wrap delays the wrap.
- in_valid = 0 in an input slot: no shift, counters hold (bubble).
- busy rises the cycle after an accepted start and falls the cycle done is high.
- Frame throughput, unstalled with continuous input: (cfg_height+HALF)*(cfg_width+HALF) shift cycles, plus 2 cycles (start latch and DONE).
- rst asserted mid-frame returns everything to reset values immediately. No partial-frame done.

## Structure
- Shared package median_pkg holds HALF, WIN_MAX=11, the window-size encodings (WS_11, WS_9, WS_7), and the state enum.
- One sub-module, raster_counter: parameterised col/row counter with enable, bounds and wrap flags. The remainder is the FSM and registered output stage.

## Test plan
- cfg 16x8, size 00, continuous in_valid, no stall → 16 px accepted per row for 8 rows. 128 win_valid pulses, first at centre (0,0), last at (7,15). done pulses after 13*21=273 shifts.
- start with cfg_width=5 → cfg_err pulse; busy stays 0, state IDLE.
- cfg_window_size=10 on start → window_size reads 11 for the whole frame.
- 12x6 frame, stall high 3 cycles at col_cnt=12 of row 2 → no clken or counter change during stall. win_valid sequence is identical apart from the 3-cycle shift.
- in_valid toggled every other cycle on a 6x6 frame → 36 pixels accepted, 36 win_valid pulses, with pad_col/pad_row high only in flush slots.
- rst pulsed at row 3 of a 16x8 frame → all outputs 0 the next cycle. A new start runs a full frame correctly.
